// File: rtl/pkt_requester.sv
// Request/packet sequencer: issues one ID per request, checks the returned
// header/footer against it and repacks pairs of 256-bit data words into 512-bit beats.
module pkt_requester #(
   parameter int unsigned DATA_WORDS_PER_PACKET = 64,
   parameter logic [31:0] FIRST_REQ_ID          = 32'd0
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         start,
   input  logic [31:0]  req_count,
   output logic         busy,
   output logic         done,
   output logic [31:0]  AXIS_RQ_TDATA,
   output logic         AXIS_RQ_TVALID,
   input  logic         AXIS_RQ_TREADY,
   input  logic [255:0] AXIS_PK_TDATA,
   input  logic         AXIS_PK_TVALID,
   output logic         AXIS_PK_TREADY,
   output logic [511:0] AXIS_OUT_TDATA,
   output logic         AXIS_OUT_TVALID,
   input  logic         AXIS_OUT_TREADY,
   output logic [15:0]  hdr_errors,
   output logic [15:0]  ftr_errors
);

   // state    | meaning
   // IDLE     | waiting for start
   // SEND_REQ | request ID offered on RQ stream
   // WAIT_HDR | waiting for packet header
   // RECV_HI  | capturing upper half of next OUT beat
   // RECV_LO  | capturing lower half, loading OUT beat
   // WAIT_FTR | waiting for footer and for the last OUT beat to drain
   typedef enum logic [2:0] {IDLE, SEND_REQ, WAIT_HDR, RECV_HI, RECV_LO, WAIT_FTR} state_t;

   localparam int CW = $clog2(DATA_WORDS_PER_PACKET + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WORDS_PER_PACKET);

   state_t         state_q, state_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           rq_valid_q, rq_valid_d;
   logic [31:0]    next_id_q, next_id_d;
   logic [31:0]    expected_id_q, expected_id_d;
   logic [31:0]    remaining_q, remaining_d;
   logic [CW-1:0]  word_cnt_q, word_cnt_d;
   logic [255:0]   hi_q, hi_d;
   logic [511:0]   out_data_q, out_data_d;
   logic           out_valid_q, out_valid_d;
   logic [15:0]    hdr_err_q, hdr_err_d;
   logic [15:0]    ftr_err_q, ftr_err_d;
   logic           ftr_seen_q, ftr_seen_d;

   logic           pk_ready;
   logic           pk_hs, rq_hs, out_hs;
   logic [CW-1:0]  cnt_plus2;

   assign cnt_plus2 = word_cnt_q + CW'(2);

   always_comb begin
      pk_ready = 1'b0;
      case (state_q)
         WAIT_HDR, RECV_HI: pk_ready = 1'b1;
         RECV_LO:           pk_ready = !out_valid_q || AXIS_OUT_TREADY;
         WAIT_FTR:          pk_ready = !ftr_seen_q;
         default:           pk_ready = 1'b0;
      endcase
   end

   assign pk_hs  = pk_ready && AXIS_PK_TVALID;
   assign rq_hs  = rq_valid_q && AXIS_RQ_TREADY;
   assign out_hs = out_valid_q && AXIS_OUT_TREADY;

   always_comb begin
      state_d       = state_q;
      done_d        = 1'b0;
      rq_valid_d    = rq_valid_q;
      next_id_d     = next_id_q;
      expected_id_d = expected_id_q;
      remaining_d   = remaining_q;
      word_cnt_d    = word_cnt_q;
      hi_d          = hi_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      hdr_err_d     = hdr_err_q;
      ftr_err_d     = ftr_err_q;
      ftr_seen_d    = ftr_seen_q;

      if (out_hs) out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (req_count == 32'd0) begin
                  done_d = 1'b1;
               end else begin
                  remaining_d = req_count;
                  rq_valid_d  = 1'b1;
                  state_d     = SEND_REQ;
               end
            end
         end
         SEND_REQ: begin
            if (rq_hs) begin
               expected_id_d = next_id_q;
               next_id_d     = next_id_q + 32'd1;
               rq_valid_d    = 1'b0;
               state_d       = WAIT_HDR;
            end
         end
         WAIT_HDR: begin
            if (pk_hs) begin
               if (AXIS_PK_TDATA[31:0] != expected_id_q && hdr_err_q != 16'hFFFF)
                  hdr_err_d = hdr_err_q + 16'd1;
               word_cnt_d = '0;
               state_d    = RECV_HI;
            end
         end
         RECV_HI: begin
            if (pk_hs) begin
               hi_d    = AXIS_PK_TDATA;
               state_d = RECV_LO;
            end
         end
         RECV_LO: begin
            if (pk_hs) begin
               out_data_d  = {hi_q, AXIS_PK_TDATA};
               out_valid_d = 1'b1;
               word_cnt_d  = cnt_plus2;
               state_d     = (cnt_plus2 == LAST_CNT) ? WAIT_FTR : RECV_HI;
            end
         end
         WAIT_FTR: begin
            if (pk_hs) begin
               if (AXIS_PK_TDATA[31:0] != expected_id_q && ftr_err_q != 16'hFFFF)
                  ftr_err_d = ftr_err_q + 16'd1;
               remaining_d = remaining_q - 32'd1;
               ftr_seen_d  = 1'b1;
            end
            // leave only once the footer is in and no OUT beat is still pending
            if ((ftr_seen_q || pk_hs) && (!out_valid_q || out_hs)) begin
               ftr_seen_d = 1'b0;
               if (remaining_d == 32'd0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = SEND_REQ;
                  rq_valid_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         rq_valid_q    <= 1'b0;
         next_id_q     <= FIRST_REQ_ID;
         expected_id_q <= '0;
         remaining_q   <= '0;
         word_cnt_q    <= '0;
         hi_q          <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         hdr_err_q     <= '0;
         ftr_err_q     <= '0;
         ftr_seen_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         rq_valid_q    <= rq_valid_d;
         next_id_q     <= next_id_d;
         expected_id_q <= expected_id_d;
         remaining_q   <= remaining_d;
         word_cnt_q    <= word_cnt_d;
         hi_q          <= hi_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         hdr_err_q     <= hdr_err_d;
         ftr_err_q     <= ftr_err_d;
         ftr_seen_q    <= ftr_seen_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign AXIS_RQ_TDATA   = next_id_q;
   assign AXIS_RQ_TVALID  = rq_valid_q;
   assign AXIS_PK_TREADY  = pk_ready;
   assign AXIS_OUT_TDATA  = out_data_q;
   assign AXIS_OUT_TVALID = out_valid_q;
   assign hdr_errors      = hdr_err_q;
   assign ftr_errors      = ftr_err_q;

endmodule

// File: tb/tb_pkt_requester.sv
// Scoreboard bench for pkt_requester: expected request IDs and OUT beats are
// queued as stimulus is driven and retired by monitors on the negative clock edge.
module tb_pkt_requester;

   localparam int N_WORDS = 64;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic [31:0]  req_count = '0;
   logic         busy, done;
   logic [31:0]  AXIS_RQ_TDATA;
   logic         AXIS_RQ_TVALID;
   logic         AXIS_RQ_TREADY = 1'b1;
   logic [255:0] AXIS_PK_TDATA = '0;
   logic         AXIS_PK_TVALID = 1'b0;
   logic         AXIS_PK_TREADY;
   logic [511:0] AXIS_OUT_TDATA;
   logic         AXIS_OUT_TVALID;
   logic         AXIS_OUT_TREADY = 1'b1;
   logic [15:0]  hdr_errors, ftr_errors;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int exp_done = 0;
   logic [31:0]  rq_exp[$];
   logic [511:0] out_exp[$];

   pkt_requester #(.DATA_WORDS_PER_PACKET(N_WORDS), .FIRST_REQ_ID(32'd0)) dut (
      .clk(clk), .resetn(resetn), .start(start), .req_count(req_count),
      .busy(busy), .done(done),
      .AXIS_RQ_TDATA(AXIS_RQ_TDATA), .AXIS_RQ_TVALID(AXIS_RQ_TVALID), .AXIS_RQ_TREADY(AXIS_RQ_TREADY),
      .AXIS_PK_TDATA(AXIS_PK_TDATA), .AXIS_PK_TVALID(AXIS_PK_TVALID), .AXIS_PK_TREADY(AXIS_PK_TREADY),
      .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TVALID(AXIS_OUT_TVALID), .AXIS_OUT_TREADY(AXIS_OUT_TREADY),
      .hdr_errors(hdr_errors), .ftr_errors(ftr_errors)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // handshakes complete on the following rising edge; inputs only move at posedge+1
   always @(negedge clk) begin
      if (AXIS_RQ_TVALID && AXIS_RQ_TREADY) begin
         check("rq_pending", 512'(rq_exp.size() > 0), 512'(1));
         if (rq_exp.size() > 0) check("rq_id", 512'(AXIS_RQ_TDATA), 512'(rq_exp.pop_front()));
      end
      if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
         check("out_pending", 512'(out_exp.size() > 0), 512'(1));
         if (out_exp.size() > 0) check("out_beat", AXIS_OUT_TDATA, out_exp.pop_front());
      end
      if (done) begin
         done_cnt++;
         check("done_after_last_beat", 512'(out_exp.size()), 512'(0));
      end
   end

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},     512'(busy), 512'(0));
      check({tag, "_done"},     512'(done), 512'(0));
      check({tag, "_rq_valid"}, 512'(AXIS_RQ_TVALID), 512'(0));
      check({tag, "_pk_ready"}, 512'(AXIS_PK_TREADY), 512'(0));
      check({tag, "_out_valid"},512'(AXIS_OUT_TVALID), 512'(0));
      check({tag, "_out_data"}, AXIS_OUT_TDATA, 512'(0));
      check({tag, "_hdr_err"},  512'(hdr_errors), 512'(0));
      check({tag, "_ftr_err"},  512'(ftr_errors), 512'(0));
      check({tag, "_rq_id"},    512'(AXIS_RQ_TDATA), 512'(0));
   endtask

   task automatic pulse_start(input logic [31:0] n);
      @(posedge clk); #1;
      start = 1'b1; req_count = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_rq();
      bit seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         seen = AXIS_RQ_TVALID && AXIS_RQ_TREADY;
      end
      @(posedge clk); #1;
      check("rq_seen", 512'(seen), 512'(1));
   endtask

   task automatic drive_beat(input logic [255:0] d);
      bit hs = 1'b0;
      AXIS_PK_TVALID = 1'b1;
      AXIS_PK_TDATA  = d;
      for (int c = 0; c < 200 && !hs; c++) begin
         @(negedge clk);
         hs = AXIS_PK_TREADY;
      end
      @(posedge clk); #1;
      AXIS_PK_TVALID = 1'b0;
      check("pk_accept", 512'(hs), 512'(1));
   endtask

   // stop_after > 0 abandons the packet after that many data words
   task automatic send_pkt(input logic [31:0] hid, input logic [31:0] fid,
                           input int stop_after, input bit lat);
      logic [255:0] w, hi;
      hi = '0;
      w = rand256(); w[31:0] = hid;
      drive_beat(w);
      for (int i = 0; i < N_WORDS; i++) begin
         w = rand256();
         if (i % 2 == 0) hi = w;
         else            out_exp.push_back({hi, w});
         drive_beat(w);
         if (lat && i == 1) begin
            check("out_valid_latency", 512'(AXIS_OUT_TVALID), 512'(1));
            check("out_data_latency", AXIS_OUT_TDATA, {hi, w});
         end
         if (i + 1 == stop_after) return;
      end
      w = rand256(); w[31:0] = fid;
      drive_beat(w);
   endtask

   task automatic wait_done(input int target);
      for (int c = 0; c < 300 && done_cnt < target; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("done_count", 512'(done_cnt), 512'(target));
      check("busy_after_done", 512'(busy), 512'(0));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      resetn = 1'b1;

      // single matching packet, ID 0
      rq_exp.push_back(32'd0);
      pulse_start(32'd1);
      check("busy_run", 512'(busy), 512'(1));
      wait_rq();
      send_pkt(32'd0, 32'd0, 0, 1'b1);
      exp_done++;
      wait_done(exp_done);
      check("hdr_err_clean", 512'(hdr_errors), 512'(0));
      check("ftr_err_clean", 512'(ftr_errors), 512'(0));

      // header and footer mismatch against expected ID 1
      rq_exp.push_back(32'd1);
      pulse_start(32'd1);
      wait_rq();
      send_pkt(32'd5, 32'd7, 0, 1'b0);
      exp_done++;
      wait_done(exp_done);
      check("hdr_err_one", 512'(hdr_errors), 512'(1));
      check("ftr_err_one", 512'(ftr_errors), 512'(1));

      // empty run
      pulse_start(32'd0);
      @(negedge clk);
      check("done_zero_run", 512'(done), 512'(1));
      exp_done++;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("no_rq_zero_run", 512'(AXIS_RQ_TVALID), 512'(0));
      end
      check("busy_zero_run", 512'(busy), 512'(0));
      check("done_count_zero_run", 512'(done_cnt), 512'(exp_done));

      // reset after the tenth data word
      rq_exp.push_back(32'd2);
      pulse_start(32'd1);
      wait_rq();
      send_pkt(32'd2, 32'd2, 10, 1'b0);
      resetn = 1'b0;
      #1;
      check_reset_outputs("midpkt_reset");
      out_exp.delete();
      rq_exp.delete();
      repeat (2) @(posedge clk); #1;
      resetn = 1'b1;
      AXIS_PK_TVALID = 1'b1;
      AXIS_PK_TDATA  = rand256();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("idle_pk_ready", 512'(AXIS_PK_TREADY), 512'(0));
         check("idle_rq_valid", 512'(AXIS_RQ_TVALID), 512'(0));
      end
      @(posedge clk); #1;
      AXIS_PK_TVALID = 1'b0;

      // three requests from reset; stray start and an OUT stall during the run
      for (int i = 0; i < 3; i++) rq_exp.push_back(32'(i));
      pulse_start(32'd3);
      for (int p = 0; p < 3; p++) begin
         wait_rq();
         fork
            send_pkt(32'(p), 32'(p), 0, 1'b0);
            begin
               if (p == 0) begin
                  repeat (10) @(posedge clk); #1;
                  check("busy_mid_run", 512'(busy), 512'(1));
                  start = 1'b1; req_count = 32'd7;
                  @(posedge clk); #1;
                  start = 1'b0;
               end
               if (p == 1) begin
                  logic [511:0] held;
                  repeat (20) @(posedge clk); #1;
                  AXIS_OUT_TREADY = 1'b0;
                  repeat (3) @(negedge clk);
                  held = AXIS_OUT_TDATA;
                  check("stall_valid", 512'(AXIS_OUT_TVALID), 512'(1));
                  for (int c = 0; c < 17; c++) begin
                     @(negedge clk);
                     check("stall_data_stable", AXIS_OUT_TDATA, held);
                  end
                  check("stall_pk_ready", 512'(AXIS_PK_TREADY), 512'(0));
                  @(posedge clk); #1;
                  AXIS_OUT_TREADY = 1'b1;
               end
            end
         join
         if (p < 2) check("done_not_early", 512'(done_cnt), 512'(exp_done));
      end
      exp_done++;
      wait_done(exp_done);

      // next run continues at ID 3; PK beats offered during SEND_REQ are refused
      rq_exp.push_back(32'd3);
      AXIS_RQ_TREADY = 1'b0;
      pulse_start(32'd1);
      AXIS_PK_TVALID = 1'b1;
      AXIS_PK_TDATA  = rand256();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("sendreq_pk_ready", 512'(AXIS_PK_TREADY), 512'(0));
         check("sendreq_rq_hold", 512'(AXIS_RQ_TVALID), 512'(1));
         check("sendreq_rq_data", 512'(AXIS_RQ_TDATA), 512'(3));
      end
      @(posedge clk); #1;
      AXIS_PK_TVALID = 1'b0;
      AXIS_RQ_TREADY = 1'b1;
      wait_rq();
      send_pkt(32'd3, 32'd3, 0, 1'b0);
      exp_done++;
      wait_done(exp_done);
      check("hdr_err_final", 512'(hdr_errors), 512'(0));
      check("ftr_err_final", 512'(ftr_errors), 512'(0));
      check("rq_queue_empty", 512'(rq_exp.size()), 512'(0));
      check("out_queue_empty", 512'(out_exp.size()), 512'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
